// File: rtl/sn74123_os.sv
// One section of an SN74123 retriggerable monostable, sampled on mclk.
// Pulse width is WIDTH mclk cycles; RETRIG=0 gives 74121-like behaviour.
module sn74123_os #(
    parameter int WIDTH  = 100,
    parameter bit RETRIG = 1'b1,
    parameter int CW     = 16
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic a_n,
    input  logic b,
    input  logic clr_n,
    output logic q,
    output logic q_n
);

    localparam logic [CW-1:0] LOAD = CW'(WIDTH - 1);

    logic          q_q, q_d;
    logic          qn_q, qn_d;
    logic          old_trig_q, old_trig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          trig;
    logic          trig_ev;

    assign trig    = ~a_n & b & clr_n;
    assign trig_ev = trig & ~old_trig_q;

    always_comb begin
        q_d        = q_q;
        qn_d       = qn_q;
        cnt_d      = cnt_q;
        old_trig_d = trig;
        if (!clr_n) begin
            q_d   = 1'b0;
            qn_d  = 1'b1;
            cnt_d = '0;
        end else if (trig_ev && !q_q) begin
            q_d   = 1'b1;
            qn_d  = 1'b0;
            cnt_d = LOAD;
        end else if (trig_ev && RETRIG) begin
            cnt_d = LOAD;
        end else if (q_q && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (q_q) begin
            q_d  = 1'b0;
            qn_d = 1'b1;
        end
    end

    // old_trig resets high so a trigger level held through reset is not an edge
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            q_q        <= 1'b0;
            qn_q       <= 1'b1;
            cnt_q      <= '0;
            old_trig_q <= 1'b1;
        end else begin
            q_q        <= q_d;
            qn_q       <= qn_d;
            cnt_q      <= cnt_d;
            old_trig_q <= old_trig_d;
        end
    end

    assign q   = q_q;
    assign q_n = qn_q;

endmodule

// File: tb/tb_sn74123_os.sv
// Bench for sn74123_os: three instances (retrig W=4, non-retrig W=4,
// retrig W=1) checked against a deadline-based pulse model.
module tb_sn74123_os;

    logic mclk = 1'b0;
    logic rst_n;
    logic a_n;
    logic b;
    logic clr_n;
    logic [2:0] qv;
    logic [2:0] qnv;

    int vectors = 0;
    int miscompares = 0;

    longint n = 0;
    longint end_t[3];
    bit     prev;
    int     wv[3] = '{4, 4, 1};
    bit     rv[3] = '{1'b1, 1'b0, 1'b1};

    always #5 mclk = ~mclk;

    sn74123_os #(.WIDTH(4), .RETRIG(1'b1), .CW(16)) u_r (
        .mclk(mclk), .rst_n(rst_n), .a_n(a_n), .b(b), .clr_n(clr_n),
        .q(qv[0]), .q_n(qnv[0])
    );

    sn74123_os #(.WIDTH(4), .RETRIG(1'b0), .CW(16)) u_nr (
        .mclk(mclk), .rst_n(rst_n), .a_n(a_n), .b(b), .clr_n(clr_n),
        .q(qv[1]), .q_n(qnv[1])
    );

    sn74123_os #(.WIDTH(1), .RETRIG(1'b1), .CW(4)) u_w1 (
        .mclk(mclk), .rst_n(rst_n), .a_n(a_n), .b(b), .clr_n(clr_n),
        .q(qv[2]), .q_n(qnv[2])
    );

    task automatic model_reset();
        for (int i = 0; i < 3; i++) end_t[i] = 0;
        prev = 1'b1;
    endtask

    // Pulse is high while the edge count is below the instance's deadline.
    task automatic model_edge();
        bit trig;
        bit ev;
        bit q_old;
        trig = !a_n && b && clr_n;
        ev   = trig && !prev;
        n++;
        for (int i = 0; i < 3; i++) begin
            q_old = (n - 1) < end_t[i];
            if (!clr_n) end_t[i] = 0;
            else if (ev && (!q_old || rv[i])) end_t[i] = n + wv[i];
        end
        prev = trig;
    endtask

    task automatic chk(input string tag);
        logic [1:0] exp;
        logic [1:0] got;
        for (int i = 0; i < 3; i++) begin
            exp = (n < end_t[i]) ? 2'b10 : 2'b01;
            got = {qv[i], qnv[i]};
            vectors++;
            assert (got === exp)
            else begin
                miscompares++;
                $error("FAIL %s dut%0d edge%0d q/q_n=%b expected %b",
                       tag, i, n, got, exp);
            end
        end
    endtask

    task automatic step(input logic a, input logic bb, input logic c,
                        input string tag);
        a_n   = a;
        b     = bb;
        clr_n = c;
        @(posedge mclk);
        #1;
        if (!rst_n) begin
            n++;
            model_reset();
        end else begin
            model_edge();
        end
        chk(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk(tag);
    endtask

    task automatic expect_q(input logic [2:0] e, input string tag);
        vectors++;
        assert (qv === e && qnv === ~e)
        else begin
            miscompares++;
            $error("FAIL %s q=%b q_n=%b expected q=%b", tag, qv, qnv, e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_n   = 1'b0;
        b     = 1'b1;
        clr_n = 1'b1;
        model_reset();
        @(posedge mclk);
        #1;
        expect_q(3'b000, "reset_state");
        rst_n = 1'b1;
        // trigger level held through reset release: no pulse
        repeat (20) step(1'b0, 1'b1, 1'b1, "powerup_guard");
        expect_q(3'b000, "powerup_quiet");

        // A-trigger, then hold a_n low: one pulse only
        step(1'b1, 1'b1, 1'b1, "a_idle");
        step(1'b0, 1'b1, 1'b1, "a_trig");
        expect_q(3'b111, "a_rise_same_edge");
        step(1'b0, 1'b1, 1'b1, "a_pulse");
        expect_q(3'b011, "w1_one_cycle");
        repeat (2) step(1'b0, 1'b1, 1'b1, "a_pulse");
        expect_q(3'b011, "a_last_high");
        step(1'b0, 1'b1, 1'b1, "a_fall");
        expect_q(3'b000, "a_end");
        repeat (6) step(1'b0, 1'b1, 1'b1, "a_hold");

        // B-trigger and re-arm
        step(1'b0, 1'b0, 1'b1, "b_low");
        repeat (6) step(1'b0, 1'b1, 1'b1, "b_pulse1");
        step(1'b0, 1'b0, 1'b1, "b_rearm");
        repeat (6) step(1'b0, 1'b1, 1'b1, "b_pulse2");

        // retrigger at k+2
        step(1'b0, 1'b0, 1'b1, "rt_idle");
        step(1'b0, 1'b1, 1'b1, "rt_k");
        step(1'b0, 1'b0, 1'b1, "rt_k1");
        step(1'b0, 1'b1, 1'b1, "rt_k2");
        step(1'b0, 1'b1, 1'b1, "rt_k3");
        step(1'b0, 1'b1, 1'b1, "rt_k4");
        expect_q(3'b001, "rt_split");
        step(1'b0, 1'b1, 1'b1, "rt_k5");
        expect_q(3'b001, "rt_k5_high");
        step(1'b0, 1'b1, 1'b1, "rt_k6");
        expect_q(3'b000, "rt_k6_low");

        // clear mid-pulse, release with trigger level present
        step(1'b1, 1'b1, 1'b1, "clr_idle");
        step(1'b0, 1'b1, 1'b1, "clr_k");
        step(1'b0, 1'b1, 1'b0, "clr_k1");
        expect_q(3'b000, "clr_wins");
        step(1'b0, 1'b1, 1'b0, "clr_hold");
        step(1'b0, 1'b1, 1'b1, "clr_release");
        expect_q(3'b111, "clr_release_trig");
        repeat (5) step(1'b0, 1'b1, 1'b1, "clr_pulse");

        // asynchronous reset mid-pulse
        step(1'b1, 1'b1, 1'b1, "ar_idle");
        step(1'b0, 1'b1, 1'b1, "ar_k");
        step(1'b0, 1'b1, 1'b1, "ar_k1");
        async_reset("ar_immediate");
        expect_q(3'b000, "ar_no_edge");
        step(1'b0, 1'b1, 1'b1, "ar_low");
        rst_n = 1'b1;
        repeat (4) step(1'b0, 1'b1, 1'b1, "ar_quiet");
        step(1'b1, 1'b1, 1'b1, "ar_idle2");
        step(1'b0, 1'b1, 1'b1, "ar_newtrig");
        expect_q(3'b111, "ar_new_pulse");
        repeat (5) step(1'b0, 1'b1, 1'b1, "ar_pulse");

        // randomized inputs
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) != 0), "rand");
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand_reset");
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'b1, "rand_in_reset");
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
